bus_xfer_seq: RTL and testbench

// Initiator side of the shared 8-bit register bus. It queues transfer commands and drives the
// per-register reg_op_e lines so that one source drives the bus and one destination captures it.
// The source is either a bus register or an immediate byte driven by this block.

---
 rtl/bus_xfer_seq_if.sv | 46 ++++
 rtl/bus_xfer_seq.sv | 160 ++++++++++++++++
 tb/tb_bus_xfer_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_xfer_seq_if.sv
// Shared types and the request/bus interface for bus_xfer_seq.
//   reg_op_e : per-register bus operation (NOP / ENABLE source / LOAD destination)
//   bus_xfer_seq_if:
//     req_valid/req_ready          command handshake
//     req_imm/req_src/req_dst/req_data  command fields
//     reg_op[NUM_REGS]             per-register op lines
//     bus                          immediate byte, 'z when not driven
//     busy/done/err                status
//   modport slave  : the sequencer side
//   modport master : the command issuer / register-file side
package bus_xfer_seq_pkg;
    typedef enum logic [1:0] {
        NOP    = 2'd0,
        ENABLE = 2'd1,
        LOAD   = 2'd2
    } reg_op_e;
endpackage

interface bus_xfer_seq_if #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
);
    import bus_xfer_seq_pkg::*;

    logic                          req_valid;
    logic                          req_ready;
    logic                          req_imm;
    logic [IDX_W-1:0]              req_src;
    logic [IDX_W-1:0]              req_dst;
    logic [7:0]                    req_data;
    reg_op_e [NUM_REGS-1:0]        reg_op;
    logic [7:0]                    bus;
    logic                          busy;
    logic                          done;
    logic                          err;

    modport slave (
        input  req_valid, req_imm, req_src, req_dst, req_data,
        output req_ready, reg_op, bus, busy, done, err
    );

    modport master (
        output req_valid, req_imm, req_src, req_dst, req_data,
        input  req_ready, reg_op, bus, busy, done, err
    );
endinterface

// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: initiator of the shared 8-bit register bus.
// Queues transfer commands in a small FIFO and sequences the per-register
// reg_op lines so one source drives the bus and one destination captures it.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   ifc    bus_xfer_seq_if.slave (command handshake, reg_op, bus, status)
// Register transfer: IDLE(pop) -> PREP (src ENABLE) -> XFER (src ENABLE,
// dst LOAD) -> IDLE with done. Immediate: IDLE(pop) -> XFER (dst LOAD,
// bus=data) -> IDLE with done. All outputs come straight from flops.
module bus_xfer_seq
    import bus_xfer_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DEPTH    = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset,
    bus_xfer_seq_if.slave ifc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    localparam logic [IDX_W:0] NREG = (IDX_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, PREP, XFER} state_e;

    typedef struct packed {
        logic             imm;
        logic [IDX_W-1:0] src;
        logic [IDX_W-1:0] dst;
        logic [7:0]       data;
    } cmd_t;

    // FIFO
    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0]   count, count_nxt;
    logic             push, pop;
    cmd_t             head, cmd_in;
    logic             head_ok;

    // FSM and registered outputs
    state_e                 state, state_n;
    logic [IDX_W-1:0]       cur_src, cur_dst;
    reg_op_e [NUM_REGS-1:0] op_q, op_n;
    logic [7:0]             bus_q, bus_n;
    logic                   bus_en, bus_en_n;
    logic                   done_q, done_n, err_q, err_n;
    logic                   busy_q, ready_q;

    assign cmd_in    = '{imm: ifc.req_imm, src: ifc.req_src, dst: ifc.req_dst, data: ifc.req_data};
    assign push      = ifc.req_valid && ready_q;   // ready_q already equals !full
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = mem[rptr];
    assign count_nxt = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    // Source index is only meaningful for register transfers.
    assign head_ok = ({1'b0, head.dst} < NREG) &&
                     (head.imm || (({1'b0, head.src} < NREG) && (head.src != head.dst)));

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= cmd_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pop && head_ok) state_n = head.imm ? XFER : PREP;
            PREP:    state_n = XFER;
            XFER:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next output values; the loop compares indices rather than indexing so
    // an out-of-range index can never select a lane.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) op_n[i] = NOP;
        bus_n    = '0;
        bus_en_n = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: if (pop) begin
                if (!head_ok) begin
                    err_n = 1'b1;
                end else if (head.imm) begin
                    for (int i = 0; i < NUM_REGS; i++)
                        if (IDX_W'(i) == head.dst) op_n[i] = LOAD;
                    bus_n    = head.data;
                    bus_en_n = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_REGS; i++)
                        if (IDX_W'(i) == head.src) op_n[i] = ENABLE;
                end
            end
            PREP: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (IDX_W'(i) == cur_src) op_n[i] = ENABLE;
                    if (IDX_W'(i) == cur_dst) op_n[i] = LOAD;
                end
            end
            XFER:    done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) op_q[i] <= NOP;
            bus_q   <= '0;
            bus_en  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            cur_src <= '0;
            cur_dst <= '0;
        end else begin
            op_q    <= op_n;
            bus_q   <= bus_n;
            bus_en  <= bus_en_n;
            done_q  <= done_n;
            err_q   <= err_n;
            busy_q  <= (count_nxt != '0) || (state_n != IDLE);
            ready_q <= (count_nxt != FULL);
            if (pop) begin
                cur_src <= head.src;
                cur_dst <= head.dst;
            end
        end
    end

    assign ifc.reg_op    = op_q;
    assign ifc.bus       = bus_en ? bus_q : 8'bz;
    assign ifc.busy      = busy_q;
    assign ifc.done      = done_q;
    assign ifc.err       = err_q;
    assign ifc.req_ready = ready_q;
endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq with a behavioural 4-register file:
// ENABLE latches the source at posedge, LOAD captures at negedge.
module tb_bus_xfer_seq;
    import bus_xfer_seq_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bus_xfer_seq_if #(.NUM_REGS(4), .IDX_W(3)) bif ();

    bus_xfer_seq #(.NUM_REGS(4), .DEPTH(4), .IDX_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .ifc   (bif)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Register-file model and bus monitors
    logic [7:0] regs [4];
    logic [7:0] latch_q [4];
    int load_cnt = 0, done_cnt = 0, err_cnt = 0, en_cyc = 0, bad_en = 0, bad_both = 0;
    int log_d [$];
    logic [7:0] log_v [$];

    initial for (int i = 0; i < 4; i++) begin regs[i] = '0; latch_q[i] = '0; end

    always @(posedge clock)
        for (int i = 0; i < 4; i++)
            if (bif.reg_op[i] == ENABLE) latch_q[i] <= regs[i];

    always @(negedge clock) begin
        int ne, nl, s, d;
        logic [7:0] v;
        ne = 0; nl = 0; s = 0; d = 0;
        for (int i = 0; i < 4; i++) begin
            if (bif.reg_op[i] == ENABLE) begin ne++; s = i; end
            if (bif.reg_op[i] == LOAD)   begin nl++; d = i; end
        end
        if (nl > 0) begin
            v = (ne > 0) ? latch_q[s] : bif.bus;
            regs[d] = v;
            load_cnt++;
            log_d.push_back(d);
            log_v.push_back(v);
        end
        if (ne > 1) bad_en++;
        en_cyc += ne;
        if (bif.done) done_cnt++;
        if (bif.err)  err_cnt++;
        if (bif.done && bif.err) bad_both++;
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic imm, input logic [2:0] src, input logic [2:0] dst,
                        input logic [7:0] data);
        int g;
        bif.req_valid = 1'b1; bif.req_imm = imm; bif.req_src = src;
        bif.req_dst = dst; bif.req_data = data;
        g = 0;
        while (!bif.req_ready && g < 100) begin @(negedge clock); g++; end
        chk("push_wait", 32'(g < 100), 1);
        @(negedge clock);
        bif.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (bif.busy && g < 200) begin @(negedge clock); g++; end
        chk("idle", 32'(bif.busy), 0);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, l0, e0, en0, base;
        int exp_d [6];
        logic [7:0] exp_v [6];
        exp_d = '{0, 3, 1, 2, 1, 0};
        exp_v = '{8'h44, 8'h22, 8'h33, 8'h44, 8'h22, 8'h22};

        bif.req_valid = 0; bif.req_imm = 0; bif.req_src = 0; bif.req_dst = 0; bif.req_data = 0;

        // 1: reset
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ops",   32'(bif.reg_op), 0);
        chk("rst_busy",  32'(bif.busy), 0);
        chk("rst_ready", 32'(bif.req_ready), 0);
        chk("rst_done",  32'(bif.done), 0);
        reset = 1'b1;
        #1 chk("ready_pre", 32'(bif.req_ready), 0);
        @(negedge clock);
        chk("ready_post", 32'(bif.req_ready), 1);
        chk("post_busy",  32'(bif.busy), 0);
        chk("post_ops",   32'(bif.reg_op), 0);

        // 2: immediate to reg1
        push(1, 0, 1, 8'hA5);
        @(negedge clock);
        chk("t2_op",   32'(bif.reg_op), 32'h08);
        chk("t2_bus",  32'(bif.bus), 32'hA5);
        chk("t2_busy", 32'(bif.busy), 1);
        @(negedge clock);
        chk("t2_done", 32'(bif.done), 1);
        chk("t2_nop",  32'(bif.reg_op), 0);
        @(negedge clock);
        chk("t2_done_clr", 32'(bif.done), 0);
        chk("t2_idle",     32'(bif.busy), 0);
        chk("t2_reg1",     32'(regs[1]), 32'hA5);

        // 3: reg0=3C, then reg0 -> reg2
        push(1, 0, 0, 8'h3C);
        wait_idle();
        d0 = done_cnt;
        push(0, 0, 2, 8'h00);
        @(negedge clock);
        chk("t3_prep", 32'(bif.reg_op), 32'h01);
        @(negedge clock);
        chk("t3_xfer", 32'(bif.reg_op), 32'h21);
        @(negedge clock);
        chk("t3_done", 32'(bif.done), 1);
        chk("t3_nop",  32'(bif.reg_op), 0);
        @(negedge clock);
        chk("t3_reg2",  32'(regs[2]), 32'h3C);
        chk("t3_reg0",  32'(regs[0]), 32'h3C);
        chk("t3_done1", 32'(done_cnt - d0), 1);

        // 4: preload 11/22/33/44, then DEPTH+2 chained register transfers
        push(1, 0, 0, 8'h11);
        push(1, 0, 1, 8'h22);
        push(1, 0, 2, 8'h33);
        push(1, 0, 3, 8'h44);
        wait_idle();
        base = log_d.size();
        d0 = done_cnt;
        bif.req_valid = 1'b1; bif.req_imm = 1'b0; bif.req_data = 8'h00;
        for (int k = 0; k < 6; k++) begin
            int g;
            case (k)
                0: begin bif.req_src = 3; bif.req_dst = 0; end
                1: begin bif.req_src = 1; bif.req_dst = 3; end
                2: begin bif.req_src = 2; bif.req_dst = 1; end
                3: begin bif.req_src = 0; bif.req_dst = 2; end
                4: begin bif.req_src = 3; bif.req_dst = 1; end
                default: begin bif.req_src = 1; bif.req_dst = 0; end
            endcase
            g = 0;
            while (!bif.req_ready && g < 100) begin @(negedge clock); g++; end
            chk("t4_wait", 32'(g < 100), 1);
            @(negedge clock);
        end
        bif.req_valid = 1'b0;
        chk("t4_full_ready", 32'(bif.req_ready), 0);
        wait_idle();
        chk("t4_nloads", 32'(log_d.size() - base), 6);
        chk("t4_ndone",  32'(done_cnt - d0), 6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < log_d.size()) begin
                chk($sformatf("t4_dst%0d", k), 32'(log_d[base+k]), 32'(exp_d[k]));
                chk($sformatf("t4_val%0d", k), 32'(log_v[base+k]), 32'(exp_v[k]));
            end
        end
        chk("t4_r0", 32'(regs[0]), 32'h22);
        chk("t4_r1", 32'(regs[1]), 32'h22);
        chk("t4_r2", 32'(regs[2]), 32'h44);
        chk("t4_r3", 32'(regs[3]), 32'h22);

        // 5: invalid commands
        e0 = err_cnt; l0 = load_cnt; en0 = en_cyc; d0 = done_cnt;
        push(0, 1, 1, 8'h00);
        push(0, 7, 0, 8'h00);
        push(1, 0, 4, 8'h5A);
        wait_idle();
        chk("t5_errs",  32'(err_cnt - e0), 3);
        chk("t5_loads", 32'(load_cnt - l0), 0);
        chk("t5_ens",   32'(en_cyc - en0), 0);
        chk("t5_done",  32'(done_cnt - d0), 0);

        // 6: reset during PREP with one command still queued
        d0 = done_cnt; l0 = load_cnt;
        push(0, 0, 1, 8'h00);
        push(0, 2, 3, 8'h00);
        chk("t6_prep", 32'(bif.reg_op), 32'h01);
        #2 reset = 1'b0;
        #1;
        chk("t6_ops",   32'(bif.reg_op), 0);
        chk("t6_busy",  32'(bif.busy), 0);
        chk("t6_ready", 32'(bif.req_ready), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        chk("t6_noload", 32'(load_cnt - l0), 0);
        chk("t6_nodone", 32'(done_cnt - d0), 0);
        chk("t6_idle",   32'(bif.busy), 0);
        chk("t6_reg1",   32'(regs[1]), 32'h22);
        chk("t6_reg3",   32'(regs[3]), 32'h22);

        chk("one_enable",    32'(bad_en), 0);
        chk("done_err_excl", 32'(bad_both), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
